// File: rtl/wb_self_write_loader.sv
// Wishbone slave that buffers eFPGA configuration words in a small FIFO and paces them
// onto the fabric self-write port, yielding the port whenever the UART loader is active.
module wb_self_write_loader #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ComActive,
    output logic        SelfWriteStrobe,
    output logic [31:0] SelfWriteData,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Bus front end state
    logic        ack_r;
    logic [31:0] dat_r;
    logic        acc_we_r;
    logic [1:0]  acc_reg_r;
    logic [31:0] acc_dat_r;

    // Control / status registers
    logic        en_r;
    logic        ie_r;
    logic [7:0]  gap_r;
    logic        ovf_r;
    logic        done_r;
    logic        com_r;
    logic [31:0] wcount_r;
    logic        irq_r;

    // FIFO storage
    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;

    // Drain engine
    state_t      state_r;
    state_t      next_state_s;
    logic        start_s;
    logic [7:0]  gap_cnt_r;
    logic        strobe_r;
    logic [31:0] swdata_r;

    // Combinational decode
    logic        hit_s;
    logic        req_s;
    logic        wr_s;
    logic        ctrl_wr_s;
    logic        stat_wr_s;
    logic        push_req_s;
    logic        wc_wr_s;
    logic        flush_s;
    logic        push_s;
    logic        pop_s;
    logic        empty_s;
    logic        full_s;
    logic        busy_s;
    logic        blocked_s;
    logic        done_set_s;
    logic        ovf_set_s;
    logic [31:0] head_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    assign hit_s = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // A held strobe is not re-accepted in the ack cycle, so every access costs two cycles.
    assign req_s = wbs_stb_i & wbs_cyc_i & hit_s & ~ack_r;

    assign wr_s       = ack_r & acc_we_r;
    assign ctrl_wr_s  = wr_s & (acc_reg_r == 2'd0);
    assign stat_wr_s  = wr_s & (acc_reg_r == 2'd1);
    assign push_req_s = wr_s & (acc_reg_r == 2'd2);
    assign wc_wr_s    = wr_s & (acc_reg_r == 2'd3);
    assign flush_s    = ctrl_wr_s & acc_dat_r[1];

    assign empty_s = (level_r == LW'(0));
    assign full_s  = (level_r == LW'(FIFO_DEPTH));
    assign busy_s  = (state_r != ST_IDLE);
    assign head_s  = mem_r[rd_ptr_r];

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign push_s    = push_req_s & ~full_s & ~flush_s;
    assign ovf_set_s = push_req_s & full_s;
    assign pop_s     = (state_r == ST_STROBE) & ~empty_s;
    assign done_set_s = pop_s & (level_r == LW'(1)) & ~push_s;

    // Using the registered copy too keeps a strobe out of the cycle after ComActive was high.
    assign blocked_s = ComActive | com_r;

    assign unused_s = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign wbs_ack_o       = ack_r;
    assign wbs_dat_o       = dat_r;
    assign SelfWriteStrobe = strobe_r;
    assign SelfWriteData   = swdata_r;
    assign irq             = irq_r;

    // Register read multiplexer
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (wbs_adr_i[3:2])
            2'd0:    rd_data_s = {16'h0000, gap_r, 5'b00000, ie_r, 1'b0, en_r};
            2'd1:    rd_data_s = {16'h0000, 8'(level_r), 2'b00, done_r, ovf_r,
                                  com_r, busy_s, full_s, empty_s};
            2'd2:    rd_data_s = 32'h0000_0000;
            2'd3:    rd_data_s = wcount_r;
            default: rd_data_s = 32'h0000_0000;
        endcase
    end

    // Bus front end: capture an access and acknowledge it one cycle later
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ack_r     <= 1'b0;
            dat_r     <= 32'h0000_0000;
            acc_we_r  <= 1'b0;
            acc_reg_r <= 2'd0;
            acc_dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= req_s;
            if (req_s) begin
                dat_r     <= wbs_we_i ? 32'h0000_0000 : rd_data_s;
                acc_we_r  <= wbs_we_i;
                acc_reg_r <= wbs_adr_i[3:2];
                acc_dat_r <= wbs_dat_i;
            end else begin
                dat_r <= 32'h0000_0000;
            end
        end
    end

    // Control, sticky status, word counter and interrupt registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            en_r     <= 1'b0;
            ie_r     <= 1'b0;
            gap_r    <= 8'h00;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            com_r    <= 1'b0;
            wcount_r <= 32'h0000_0000;
            irq_r    <= 1'b0;
        end else begin
            com_r <= ComActive;
            if (ctrl_wr_s) begin
                en_r  <= acc_dat_r[0];
                ie_r  <= acc_dat_r[2];
                gap_r <= acc_dat_r[15:8];
            end
            ovf_r  <= ovf_set_s  | (ovf_r  & ~(stat_wr_s & acc_dat_r[4]));
            done_r <= done_set_s | (done_r & ~(stat_wr_s & acc_dat_r[5]));
            if (wc_wr_s) begin
                wcount_r <= 32'h0000_0000;
            end else if (pop_s) begin
                wcount_r <= wcount_r + 32'd1;
            end
            irq_r <= done_r & ie_r;
        end
    end

    // Word FIFO; a flush empties it while any strobe already in flight still completes
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= acc_dat_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LW'(1);
            end else if (!push_s && pop_s) begin
                level_r <= level_r - LW'(1);
            end
        end
    end

    // Drain FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_r && !empty_s && !blocked_s && !flush_s) begin
                    next_state_s = ST_STROBE;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (flush_s) begin
                    next_state_s = ST_IDLE;
                end else if (gap_r != 8'h00) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (flush_s || (gap_cnt_r <= 8'd1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Drain FSM state register with gap counter
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'h00;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_STROBE) begin
                gap_cnt_r <= gap_r;
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r - 8'd1;
            end
        end
    end

    // Self-write port outputs; data is held between strobes
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            strobe_r <= 1'b0;
            swdata_r <= 32'h0000_0000;
        end else begin
            strobe_r <= start_s;
            if (start_s) begin
                swdata_r <= head_s;
            end
        end
    end

endmodule

// File: tb/tb_wb_self_write_loader.sv
// Self-checking bench for wb_self_write_loader: register table, directed drain sequences
// and a randomized phase scored against an in-order word queue.
module tb_wb_self_write_loader;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ComActive = 1'b0;
    logic        SelfWriteStrobe;
    logic [31:0] SelfWriteData;
    logic        irq;

    wb_self_write_loader #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .resetn(resetn),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .ComActive(ComActive),
        .SelfWriteStrobe(SelfWriteStrobe), .SelfWriteData(SelfWriteData),
        .irq(irq)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: words accepted by the FIFO, in the order they must be strobed out
    logic [31:0] exp_q[$];
    int          strobe_cyc[$];
    logic        ovf_exp = 1'b0;
    int          min_space = 2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor sampled mid-cycle
    initial begin
        logic prev_com;
        logic prev_ack;
        int   last_strobe;
        prev_com = 1'b0;
        prev_ack = 1'b0;
        last_strobe = -1000;
        forever begin
            @(negedge CLK);
            if (resetn) begin
                if (SelfWriteStrobe) begin
                    strobe_cyc.push_back(cyc);
                    chk("no_strobe_after_comactive", {31'h0, prev_com}, 32'h0);
                    chk("strobe_spacing", {31'h0, (cyc - last_strobe) >= min_space}, 32'h1);
                    last_strobe = cyc;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: data %h with no word pending", SelfWriteData);
                    end else begin
                        chk("strobe_data", SelfWriteData, exp_q.pop_front());
                    end
                end
                if (wbs_ack_o) chk("ack_not_back_to_back", {31'h0, prev_ack}, 32'h0);
                else           chk("dat_zero_without_ack", wbs_dat_o, 32'h0);
            end
            prev_com = ComActive;
            prev_ack = wbs_ack_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] r, input logic [31:0] wd,
                        output logic [31:0] rd, output int ack_cyc);
        logic was_ack;
        int   waited;
        was_ack   = wbs_ack_o;
        waited    = 0;
        wbs_adr_i = BASE | {28'h0, r, 2'b00};
        wbs_dat_i = wd;
        wbs_we_i  = we;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        @(posedge CLK);
        #1;
        while (!wbs_ack_o && waited < 4) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        rd      = wbs_dat_o;
        ack_cyc = cyc;
        if (!wbs_ack_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within %0d cycles", waited + 1);
        end else begin
            chk("ack_latency", waited, was_ack ? 32'd1 : 32'd0);
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_dat_i = 32'h0;
    endtask

    task automatic reg_wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] rd;
        int          t;
        xfer(1'b1, r, d, rd, t);
        if (r == 2'd0 && d[1]) begin
            #5;
            exp_q.delete();
        end
    endtask

    task automatic reg_rd(input logic [1:0] r, output logic [31:0] d);
        int t;
        xfer(1'b0, r, 32'h0, d, t);
    endtask

    task automatic push(input logic [31:0] w, output int t);
        logic [31:0] rd;
        xfer(1'b1, 2'd2, w, rd, t);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else ovf_exp = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  r;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] rd;
    int          t0, t1, s0, k, g;
    logic        seen;

    initial begin
        tbl[0] = '{1'b1, 2'd0, 32'h0000_AB04, 32'h0};
        tbl[1] = '{1'b0, 2'd0, 32'h0,         32'h0000_AB04};
        tbl[2] = '{1'b1, 2'd0, 32'hFFFF_0303, 32'h0};
        tbl[3] = '{1'b0, 2'd0, 32'h0,         32'h0000_0301};
        tbl[4] = '{1'b1, 2'd3, 32'h1234_5678, 32'h0};
        tbl[5] = '{1'b0, 2'd3, 32'h0,         32'h0};
        tbl[6] = '{1'b0, 2'd2, 32'h0,         32'h0};
        tbl[7] = '{1'b1, 2'd0, 32'h0,         32'h0};
        tbl[8] = '{1'b0, 2'd1, 32'h0,         32'h0000_0001};

        // Reset state
        tick(3);
        chk("reset_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("reset_dat", wbs_dat_o, 32'h0);
        chk("reset_strobe", {31'h0, SelfWriteStrobe}, 32'h0);
        chk("reset_swdata", SelfWriteData, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        tick(2);
        reg_rd(2'd1, rd);
        chk("reset_status", rd, 32'h0000_0001);

        // Register table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].we) reg_wr(tbl[i].r, tbl[i].wd);
            else begin
                reg_rd(tbl[i].r, rd);
                chk($sformatf("table_read_%0d", i), rd, tbl[i].exp);
            end
        end

        // Unselected address is never acknowledged
        wbs_adr_i = BASE + 32'h10;
        wbs_we_i  = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick(1);
            if (wbs_ack_o) seen = 1'b1;
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        chk("unselected_no_ack", {31'h0, seen}, 32'h0);
        tick(2);

        // GAP=0 drain of three words
        min_space = 2;
        reg_wr(2'd0, 32'h0000_0001);
        s0 = strobe_cyc.size();
        push(32'hA5A5_0001, t1);
        push(32'hA5A5_0002, t0);
        push(32'hA5A5_0003, t0);
        tick(10);
        chk("gap0_count", strobe_cyc.size() - s0, 32'd3);
        if (strobe_cyc.size() >= s0 + 3) begin
            chk("gap0_latency", strobe_cyc[s0] - t1, 32'd2);
            chk("gap0_space1", strobe_cyc[s0+1] - strobe_cyc[s0], 32'd2);
            chk("gap0_space2", strobe_cyc[s0+2] - strobe_cyc[s0+1], 32'd2);
        end
        reg_rd(2'd3, rd);
        chk("wcount_3", rd, 32'd3);
        reg_rd(2'd1, rd);
        chk("status_done", rd, 32'h0000_0021);

        // GAP=3 spacing
        min_space = 5;
        reg_wr(2'd0, 32'h0000_0301);
        s0 = strobe_cyc.size();
        push(32'h0BAD_0001, t1);
        push(32'h0BAD_0002, t0);
        tick(15);
        chk("gap3_count", strobe_cyc.size() - s0, 32'd2);
        if (strobe_cyc.size() >= s0 + 2) begin
            chk("gap3_latency", strobe_cyc[s0] - t1, 32'd2);
            chk("gap3_space", strobe_cyc[s0+1] - strobe_cyc[s0], 32'd5);
        end

        // Blocking by ComActive
        min_space = 2;
        reg_wr(2'd0, 32'h0000_0001);
        ComActive = 1'b1;
        tick(2);
        s0 = strobe_cyc.size();
        for (int i = 0; i < 4; i++) push(32'hC0DE_0000 + i, t0);
        tick(8);
        chk("blocked_no_strobe", strobe_cyc.size() - s0, 32'd0);
        reg_rd(2'd1, rd);
        chk("status_blocked", rd, 32'h0000_0428);
        tick(1);
        ComActive = 1'b0;
        k = cyc;
        tick(12);
        chk("unblock_count", strobe_cyc.size() - s0, 32'd4);
        if (strobe_cyc.size() >= s0 + 4) begin
            chk("unblock_first", strobe_cyc[s0] - k, 32'd2);
            chk("unblock_space", strobe_cyc[s0+3] - strobe_cyc[s0], 32'd6);
        end

        // Overflow with EN=0
        reg_wr(2'd0, 32'h0);
        reg_wr(2'd1, 32'h0000_0030);
        ovf_exp = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(32'hF00D_0000 + i, t0);
        chk("ovf_predicted", {31'h0, ovf_exp}, 32'h1);
        reg_rd(2'd1, rd);
        chk("status_full_ovf", rd, 32'h0000_0812);
        reg_wr(2'd1, 32'h0000_0010);
        reg_rd(2'd1, rd);
        chk("status_ovf_cleared", rd, 32'h0000_0802);

        // Flush, then DONE/IE interrupt
        s0 = strobe_cyc.size();
        reg_wr(2'd0, 32'h0000_0003);
        reg_rd(2'd1, rd);
        chk("flush_empty", rd, 32'h0000_0001);
        tick(6);
        chk("flush_no_strobes", strobe_cyc.size() - s0, 32'd0);
        reg_wr(2'd0, 32'h0000_0005);
        push(32'h1EAF_0001, t0);
        tick(6);
        chk("irq_set", {31'h0, irq}, 32'h1);
        reg_wr(2'd1, 32'h0000_0020);
        tick(2);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Randomized phase
        reg_wr(2'd1, 32'h0000_0030);
        reg_wr(2'd3, 32'h0);
        s0 = strobe_cyc.size();
        ovf_exp = 1'b0;
        g = $urandom_range(0, 2);
        min_space = g + 2;
        reg_wr(2'd0, {16'h0, 8'(g), 8'h01});
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6) push($urandom, t0);
            else if (k < 8) begin
                ComActive = ~ComActive;
                tick(1);
            end else tick($urandom_range(1, 4));
        end
        ComActive = 1'b0;
        tick(80);
        chk("rand_queue_drained", exp_q.size(), 32'd0);
        reg_rd(2'd3, rd);
        chk("rand_wcount", rd, strobe_cyc.size() - s0);
        reg_rd(2'd1, rd);
        chk("rand_ovf", {31'h0, rd[4]}, {31'h0, ovf_exp});
        chk("rand_empty", {31'h0, rd[0]}, 32'h1);

        // Asynchronous reset during a strobe
        min_space = 2;
        reg_wr(2'd0, 32'h0000_0001);
        push(32'h5EED_0001, t0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick(1);
            seen = SelfWriteStrobe;
        end
        chk("strobe_before_reset", {31'h0, seen}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("reset_drops_strobe", {31'h0, SelfWriteStrobe}, 32'h0);
        chk("reset_clears_swdata", SelfWriteData, 32'h0);
        exp_q.delete();
        tick(2);
        resetn = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
